// File: rtl/hicore_dtcm_bank_ctrl_pkg.sv
// Shared configuration for the HiCore DTCM bank controller: default geometry,
// byte-offset derivation and the response-entry layout.
package hicore_dtcm_bank_ctrl_pkg;

    localparam int HiCore_DTCM_DW    = 32;
    localparam int HiCore_DTCM_DEPTH = 14;

    // Number of byte-offset address bits for a given data width.
    function automatic int dtcm_ofs(input int dw);
        return $clog2(dw / 8);
    endfunction

    typedef struct packed {
        logic                      err;
        logic [HiCore_DTCM_DW-1:0] rdata;
    } dtcm_rsp_t;

endpackage

// File: rtl/hicore_dtcm_bank_ctrl_if.sv
// ICB command/response bundle between the LSU master and the DTCM controller.
interface hicore_dtcm_bank_ctrl_if
    import hicore_dtcm_bank_ctrl_pkg::*;
#(
    parameter int DW = HiCore_DTCM_DW,
    parameter int AW = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_read;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/hicore_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count; push and pop may
// happen in the same cycle.
module hicore_rsp_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Pointers wrap explicitly so non-power-of-two depths work.
    assign wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
    assign rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

    always_comb begin
        cnt_next = cnt_reg;
        case ({push, pop})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_next;
            if (pop)  rd_ptr_reg <= rd_ptr_next;
            cnt_reg <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr_reg] <= push_data;
    end

    assign pop_data = store[rd_ptr_reg];
    assign cnt      = cnt_reg;

endmodule

// File: rtl/hicore_dtcm_bank_ctrl.sv
// DTCM bank controller: byte-masked single-port RAM with 1-cycle read plus an
// in-order response buffer. Optional per-byte parity via HICORE_DTCM_PARITY_EN.
module hicore_dtcm_bank_ctrl
    import hicore_dtcm_bank_ctrl_pkg::*;
#(
    parameter int DW        = HiCore_DTCM_DW,
    parameter int AW        = 32,
    parameter int RAM_DEPTH = HiCore_DTCM_DEPTH,
    parameter int RSP_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    hicore_dtcm_bank_ctrl_if.slave  mem_icb,
    output logic                    busy
);
    localparam int OFS   = dtcm_ofs(DW);
    localparam int NB    = DW / 8;
    localparam int WORDS = 1 << RAM_DEPTH;
    localparam int CW    = $clog2(RSP_DEPTH + 1);

    logic                 cmd_ready_w;
    logic                 cmd_fire;
    logic                 out_of_range;
    logic                 ram_en;
    logic [RAM_DEPTH-1:0] word_idx;
    logic [DW-1:0]        ram_q;

    logic                 inflight_reg;
    logic                 inflight_rd_reg;
    logic                 inflight_oor_reg;
    logic                 inflight_err;
    logic [DW-1:0]        inflight_rdata;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_nonempty;
    logic [DW:0]          fifo_head;
    logic [CW-1:0]        fifo_cnt;
    logic [CW-1:0]        rsp_cnt;

    assign cmd_fire     = mem_icb.cmd_valid & cmd_ready_w;
    assign word_idx     = mem_icb.cmd_addr[RAM_DEPTH+OFS-1:OFS];
    assign out_of_range = |(mem_icb.cmd_addr >> (RAM_DEPTH + OFS));
    assign ram_en       = cmd_fire & ~out_of_range;

`ifdef HICORE_DTCM_PARITY_EN
    logic [NB-1:0] par_err_lane;
`endif

    // One RAM per byte lane; the read register captures the pre-write word.
    for (genvar gi = 0; gi < NB; gi++) begin : lane_g
        logic [7:0] lane_mem [WORDS];
        logic [7:0] lane_q;

        always_ff @(posedge clk) begin
            if (ram_en) begin
                if (!mem_icb.cmd_read && mem_icb.cmd_wmask[gi])
                    lane_mem[word_idx] <= mem_icb.cmd_wdata[gi*8 +: 8];
                lane_q <= lane_mem[word_idx];
            end
        end
        assign ram_q[gi*8 +: 8] = lane_q;

`ifdef HICORE_DTCM_PARITY_EN
        logic lane_par_mem [WORDS];
        logic lane_par_q;

        always_ff @(posedge clk) begin
            if (ram_en) begin
                if (!mem_icb.cmd_read && mem_icb.cmd_wmask[gi])
                    lane_par_mem[word_idx] <= ^mem_icb.cmd_wdata[gi*8 +: 8];
                lane_par_q <= lane_par_mem[word_idx];
            end
        end
        assign par_err_lane[gi] = lane_par_q ^ (^lane_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_reg     <= 1'b0;
            inflight_rd_reg  <= 1'b0;
            inflight_oor_reg <= 1'b0;
        end else begin
            inflight_reg     <= cmd_fire;
            inflight_rd_reg  <= cmd_fire & mem_icb.cmd_read & ~out_of_range;
            inflight_oor_reg <= cmd_fire & out_of_range;
        end
    end

    // Writes and out-of-range accesses return zero data.
    assign inflight_rdata = inflight_rd_reg ? ram_q : '0;
`ifdef HICORE_DTCM_PARITY_EN
    assign inflight_err = inflight_oor_reg | (inflight_rd_reg & (|par_err_lane));
`else
    assign inflight_err = inflight_oor_reg;
`endif

    assign fifo_nonempty = (fifo_cnt != '0);
    assign fifo_pop      = fifo_nonempty & mem_icb.rsp_ready;
    assign fifo_push     = inflight_reg & (fifo_nonempty | ~mem_icb.rsp_ready);

    hicore_rsp_fifo #(
        .W     (DW + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({inflight_err, inflight_rdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .cnt       (fifo_cnt)
    );

    // Credits come from registers only, so rsp_ready never reaches cmd_ready.
    assign rsp_cnt     = fifo_cnt + CW'(inflight_reg);
    assign cmd_ready_w = (rsp_cnt < CW'(RSP_DEPTH));
    assign busy        = (rsp_cnt != '0);

    assign mem_icb.cmd_ready = cmd_ready_w;
    assign mem_icb.rsp_valid = fifo_nonempty | inflight_reg;
    assign mem_icb.rsp_err   = fifo_nonempty ? fifo_head[DW] : inflight_err;
    assign mem_icb.rsp_rdata = fifo_nonempty ? fifo_head[DW-1:0] : inflight_rdata;

endmodule

// File: tb/tb_hicore_dtcm_bank_ctrl.sv
// Directed scoreboard bench for hicore_dtcm_bank_ctrl (DW=32, RAM_DEPTH=14, RSP_DEPTH=2).
module tb_hicore_dtcm_bank_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    hicore_dtcm_bank_ctrl_if #(.DW(DW), .AW(AW)) mem_icb ();

    hicore_dtcm_bank_ctrl #(
        .DW        (DW),
        .AW        (AW),
        .RAM_DEPTH (14),
        .RSP_DEPTH (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_icb (mem_icb),
        .busy    (busy)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        int          id;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] tbl [8];
    int          errors  = 0;
    int          checks  = 0;
    int          cyc     = 0;
    int          cmd_id  = 0;
    bit          chk_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expectations pushed on command acceptance, popped on response handshake.
    always @(negedge clk) begin
        exp_t        e;
        int          idx;
        logic        oor;
        logic [31:0] old;
        if (rst) begin
            sb.delete();
        end else begin
            if (mem_icb.rsp_valid && mem_icb.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_pending", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb.pop_front();
                    $display("rsp id=%0d err=%0b rdata=%08h exp_err=%0b exp_rdata=%08h",
                             e.id, mem_icb.rsp_err, mem_icb.rsp_rdata, e.err, e.rdata);
                    chk("rsp_err", 64'(mem_icb.rsp_err), 64'(e.err));
                    chk("rsp_rdata", 64'(mem_icb.rsp_rdata), 64'(e.rdata));
                    if (chk_lat) chk("rsp_latency", 64'(cyc), 64'(e.cyc + 1));
                end
            end
            if (mem_icb.cmd_valid && mem_icb.cmd_ready) begin
                idx = int'(mem_icb.cmd_addr[15:2]);
                oor = |mem_icb.cmd_addr[31:16];
                e.cyc = cyc;
                e.id  = cmd_id;
                if (oor) begin
                    e.err = 1'b1;
                    e.rdata = '0;
                end else if (mem_icb.cmd_read) begin
                    e.err = 1'b0;
                    e.rdata = model.exists(idx) ? model[idx] : 'x;
                end else begin
                    e.err = 1'b0;
                    e.rdata = '0;
                    old = model.exists(idx) ? model[idx] : 'x;
                    for (int b = 0; b < 4; b++)
                        if (mem_icb.cmd_wmask[b]) old[b*8 +: 8] = mem_icb.cmd_wdata[b*8 +: 8];
                    model[idx] = old;
                end
                $display("cmd id=%0d %s addr=%08h wdata=%08h wmask=%b",
                         cmd_id, mem_icb.cmd_read ? "RD" : "WR", mem_icb.cmd_addr,
                         mem_icb.cmd_wdata, mem_icb.cmd_wmask);
                sb.push_back(e);
                cmd_id++;
            end
        end
    end

    task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        mem_icb.cmd_valid = 1'b1;
        mem_icb.cmd_read  = rd;
        mem_icb.cmd_addr  = a;
        mem_icb.cmd_wdata = d;
        mem_icb.cmd_wmask = m;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = mem_icb.cmd_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        chk("cmd_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle();
        mem_icb.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int w;
        int acc_n;
        int k;
        bit a;

        rst = 1'b1;
        mem_icb.cmd_valid = 1'b0;
        mem_icb.cmd_read  = 1'b0;
        mem_icb.cmd_addr  = '0;
        mem_icb.cmd_wdata = '0;
        mem_icb.cmd_wmask = '0;
        mem_icb.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) tbl[i] = 32'hC0DE_0000 + 32'(i * 17);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(mem_icb.rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'(mem_icb.rsp_err), 64'd0);
        chk("rst_rsp_rdata", 64'(mem_icb.rsp_rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(mem_icb.cmd_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full write then read-back, then partial-mask overwrite.
        chk_lat = 1'b1;
        send(1'b0, 32'h40, 32'hDEAD_BEEF, 4'hF, w);
        send(1'b1, 32'h40, 32'h0, 4'h0, w);
        send(1'b0, 32'h40, 32'h1122_3344, 4'b0101, w);
        send(1'b1, 32'h40, 32'h0, 4'h0, w);
        idle();
        drain();
        chk("partial_mask_model", 64'(model[16]), 64'h0000_0000_DE22_BE44);

        // Fill words 0..7, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) send(1'b0, 32'(i * 4), tbl[i], 4'hF, w);
        idle();
        drain();
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'(i * 4), 32'h0, 4'h0, w);
            chk("b2b_ready_wait", 64'(w), 64'd1);
        end
        idle();
        drain();

        // Back-pressure: rsp_ready low for 5 cycles with commands offered.
        chk_lat = 1'b0;
        mem_icb.rsp_ready = 1'b0;
        mem_icb.cmd_valid = 1'b1;
        mem_icb.cmd_read  = 1'b1;
        mem_icb.cmd_addr  = 32'h0;
        acc_n = 0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(mem_icb.rsp_valid), 64'(i > 0));
            if (mem_icb.rsp_valid) begin
                chk("bp_rsp_stable", 64'(mem_icb.rsp_rdata), 64'(tbl[0]));
                chk("bp_rsp_err", 64'(mem_icb.rsp_err), 64'd0);
            end
            a = mem_icb.cmd_ready;
            if (a) acc_n++;
            @(posedge clk);
            #1;
            if (a) begin
                k++;
                mem_icb.cmd_addr = 32'(k * 4);
            end
        end
        chk("bp_accepted", 64'(acc_n), 64'd2);
        chk("bp_cmd_ready", 64'(mem_icb.cmd_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        mem_icb.rsp_ready = 1'b1;
        send(1'b1, 32'h8, 32'h0, 4'h0, w);
        idle();
        drain();

        // Out-of-range write and read; word 0 must be untouched.
        chk_lat = 1'b1;
        send(1'b0, 32'h1_0000, 32'h1234_5678, 4'hF, w);
        send(1'b1, 32'h1_0000, 32'h0, 4'h0, w);
        send(1'b1, 32'h0, 32'h0, 4'h0, w);
        idle();
        drain();

        // Reset with two responses pending.
        chk_lat = 1'b0;
        mem_icb.rsp_ready = 1'b0;
        send(1'b1, 32'h4, 32'h0, 4'h0, w);
        send(1'b1, 32'h8, 32'h0, 4'h0, w);
        idle();
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_cmd_ready", 64'(mem_icb.cmd_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", 64'(mem_icb.rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 64'(mem_icb.cmd_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        mem_icb.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send(1'b1, 32'h40, 32'h0, 4'h0, w);
        send(1'b1, 32'h1C, 32'h0, 4'h0, w);
        idle();
        drain();

        chk("sb_final_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hicore_dtcm_bank_ctrl.md
Name: hicore_dtcm_bank_ctrl

Overview:
Second-generation DTCM controller for the HiCore LSU ICB port. It adds width and depth parameters, an internal byte-masked single-port RAM with 1-cycle read, and a response buffer that holds read data while the response is stalled. It also returns an out-of-range error response and sustains one transaction per cycle without any combinational rsp_ready->cmd_ready path. It sits between the LSU ICB master and the data memory.

Parameters:
DW, 32, data width in bits; 32 or 64.
AW, 32, ICB address width.
RAM_DEPTH, 14, log2 of RAM word count.
RSP_DEPTH, 2, response credits (in-flight + buffered); minimum 2.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous reset, active-high.
mem_icb_cmd_valid  input  1  command valid.
mem_icb_cmd_ready  output  1  command accepted when valid&ready.
mem_icb_cmd_read  input  1  1=read, 0=write.
mem_icb_cmd_addr  input  AW  byte address.
mem_icb_cmd_wdata  input  DW  write data.
mem_icb_cmd_wmask  input  DW/8  byte write enables.
mem_icb_rsp_valid  output  1  response valid.
mem_icb_rsp_ready  input  1  response accepted when valid&ready.
mem_icb_rsp_err  output  1  response error flag.
mem_icb_rsp_rdata  output  DW  read data.
busy  output  1  any transaction in flight or buffered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Address decode: OFS=log2(DW/8). Word index = addr[RAM_DEPTH+OFS-1:OFS]. Low OFS bits are ignored.
- Out of range: any 1 in addr[AW-1:RAM_DEPTH+OFS] is out of range. An out-of-range write does not update the RAM. The response has err=1 and rdata=0.
- Writes: only bytes with wmask=1 change. The response has err=0 and rdata=0.
- Reads: rdata = word as stored before any write accepted in the same cycle (read-first).
- Credit rule: cnt = inflight (0/1) + fifo_cnt. cmd_ready = (cnt < RSP_DEPTH). cmd_ready depends only on registers.
- Pipeline: an accepted command sets inflight=1 for the next cycle.
  - Cycle T+1, FIFO empty: the RAM output drives rsp directly, so rsp_valid is high one cycle after acceptance.
  - If rsp_ready=0 at T+1, or the FIFO is non-empty, the in-flight result is pushed into the FIFO (data and err).
- Ordering: responses are strictly in order. The FIFO head has priority over the in-flight result.
- Throughput: with rsp_ready held at 1, one command and one response per cycle.
- Stall: rsp_valid, rsp_err and rsp_rdata stay stable while rsp_valid & !rsp_ready.
- Simultaneous push and pop on the FIFO in the same cycle: fifo_cnt unchanged, pointers wrap modulo RSP_DEPTH.
- Full: cnt==RSP_DEPTH forces cmd_ready=0. No command is dropped.
- busy = (cnt != 0).
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, cmd_ready=1.
- Reset mid-transaction: inflight and the FIFO are cleared and pending responses are discarded. RAM contents are not reset.

Optional Feature:
Macro HICORE_DTCM_PARITY_EN.
- Defined: the RAM stores one even-parity bit per byte, written with the byte under wmask. On a read, any byte parity mismatch gives rsp_err=1, with rdata still returned. An out-of-range access still gives err=1.
- Undefined: no parity storage. rsp_err is set for out-of-range accesses only.

Decomposition:
- Shared package (config include): HiCore_DTCM_DW, HiCore_DTCM_DEPTH, OFS derivation, and the response-entry typedef {err, rdata}.
- One sub-module, hicore_rsp_fifo: RSP_DEPTH-entry synchronous FIFO with count output, simultaneous push/pop, and async active-high reset.
- The RAM array is inferred inside hicore_dtcm_bank_ctrl.

Test Plan:
- Write/read, DW=32: write 0xDEADBEEF at 0x40 with mask 0xF, then read 0x40 → write rsp err=0, rdata=0; read rsp rdata=0xDEADBEEF one cycle after acceptance.
- Partial mask: write 0x11223344 at 0x40 with mask 0b0101 over 0xDEADBEEF, then read → rdata=0xDE22BE44.
- Back-to-back: 8 reads of 0x0..0x1C with rsp_ready=1 → cmd_ready constantly 1, 8 in-order responses on consecutive cycles.
- Back-pressure: rsp_ready=0 for 5 cycles while cmd_valid=1 → exactly 2 accepted, cmd_ready=0 after that, rsp data stable. Release → both delivered in order, then accepts resume.
- Out of range: RAM_DEPTH=14, write 0x12345678 at 0x10000, then read 0x10000 → both responses err=1, rdata=0. The RAM word at index 0 is unchanged.
- Reset mid-operation: assert rst with 2 responses pending → rsp_valid=0 immediately, busy=0, cmd_ready=1 after release. A later read returns previously written data.
